// File: rtl/score_display_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// It latches all four BCD digits once per frame so that a display never shows a torn score.
module score_display_scan #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned GUARD    = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] value1,
   input  logic [3:0] value2,
   input  logic [3:0] value3,
   input  logic [3:0] value4,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [7:0] seg,
   output logic       frame_tick
);

   localparam int unsigned CntW = $clog2(SCAN_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] GuardC = CntW'(GUARD);

   typedef enum logic {StInit, StScan} state_t;

   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [3:0][3:0]     snap_q, snap_d;
   logic                blank_q, blank_d;
   logic [3:0]          an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                tick_q, tick_d;
   logic [3:0]          lz;
   logic [3:0]          digit;

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      unique case (d)
         4'd0:    seg_code = 8'hC0;
         4'd1:    seg_code = 8'hF9;
         4'd2:    seg_code = 8'hA4;
         4'd3:    seg_code = 8'hB0;
         4'd4:    seg_code = 8'h99;
         4'd5:    seg_code = 8'h92;
         4'd6:    seg_code = 8'h82;
         4'd7:    seg_code = 8'hF8;
         4'd8:    seg_code = 8'h80;
         4'd9:    seg_code = 8'h90;
         default: seg_code = 8'hBF;
      endcase
   endfunction

   // lz[i]: digit i and every digit to its left are zero; units digit never blanks
   always_comb begin
      lz[0] = (snap_q[0] == 4'd0);
      lz[1] = lz[0] && (snap_q[1] == 4'd0);
      lz[2] = lz[1] && (snap_q[2] == 4'd0);
      lz[3] = 1'b0;
   end

   assign digit = snap_q[idx_q];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      blank_d = blank_q;
      tick_d  = 1'b0;
      an_d    = 4'b1111;
      seg_d   = 8'hFF;
      unique case (state_q)
         StInit: begin
            snap_d[0] = value1;
            snap_d[1] = value2;
            snap_d[2] = value3;
            snap_d[3] = value4;
            blank_d   = blank_lz;
            tick_d    = 1'b1;
            idx_d     = 2'd0;
            cnt_d     = '0;
            state_d   = StScan;
         end
         StScan: begin
            if (cnt_q == CntMax) begin
               cnt_d = '0;
               if (idx_q == 2'd3) state_d = StInit;
               else               idx_d   = idx_q + 2'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if ((cnt_q >= GuardC) && !(blank_q && lz[idx_q])) begin
               an_d  = ~(4'b1000 >> idx_q);
               seg_d = seg_code(digit);
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StInit;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         snap_q  <= '0;
         blank_q <= 1'b0;
         an_q    <= 4'b1111;
         seg_q   <= 8'hFF;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         blank_q <= blank_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         tick_q  <= tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Randomised and directed checks of score_display_scan against a frame-phase reference model.
module tb_score_display_scan;

   localparam int unsigned SD = 8;
   localparam int unsigned GD = 2;
   localparam int FRAME = 4 * SD + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] value1 = 4'd0, value2 = 4'd0, value3 = 4'd0, value4 = 4'd0;
   logic       blank_lz = 1'b0;
   logic [3:0] an;
   logic [7:0] seg;
   logic       frame_tick;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   // model: m_p is the frame phase seen by the next edge (0 = snapshot load)
   int         m_p;
   logic [3:0] m_d [4];
   logic       m_bl;
   logic [3:0] exp_an;
   logic [7:0] exp_seg;
   logic       exp_ft;

   score_display_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
      .clk(clk), .rst(rst), .value1(value1), .value2(value2), .value3(value3),
      .value4(value4), .blank_lz(blank_lz), .an(an), .seg(seg), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] model_out(input int p);
      logic [7:0] codes [10];
      int slot, c;
      bit dark;
      codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      if (p == 0) return {4'hF, 8'hFF};
      slot = (p - 1) / SD;
      c = (p - 1) % SD;
      if (c < GD) return {4'hF, 8'hFF};
      dark = m_bl && (slot < 3);
      for (int i = 0; i <= slot; i++) if (m_d[i] != 4'd0) dark = 1'b0;
      if (dark) return {4'hF, 8'hFF};
      return {~(4'b0001 << (3 - slot)), (m_d[slot] > 4'd9) ? 8'hBF : codes[m_d[slot]]};
   endfunction

   task automatic step();
      @(posedge clk);
      {exp_an, exp_seg} = model_out(m_p);
      exp_ft = (m_p == 0);
      if (m_p == 0) begin
         m_d[0] = value1; m_d[1] = value2; m_d[2] = value3; m_d[3] = value4;
         m_bl = blank_lz;
      end
      m_p = (m_p == FRAME - 1) ? 0 : m_p + 1;
      cycle++;
      #1;
   endtask

   task automatic apply(input logic [3:0] a, b, c, d, input logic bl);
      value1 = a; value2 = b; value3 = c; value4 = d; blank_lz = bl;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_p = 0; m_bl = 1'b0;
      for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
   endtask

   task automatic run_checked(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         checks++;
         if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
            failures++;
            $display("FAIL %s cyc=%0d got an=%h seg=%h ft=%b want an=%h seg=%h ft=%b",
                     name, cycle, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got an=%h seg=%h ft=%b want an=f seg=ff ft=0",
                     an, seg, frame_tick);
         end
      end
   endtask

   task automatic test_basic();
      int last_tick;
      apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      do_reset();
      cycle = 0;
      last_tick = -1;
      step();
      checks++;
      if (frame_tick !== 1'b1) begin
         failures++;
         $display("FAIL first_tick got ft=%b want 1 at cycle 1", frame_tick);
      end
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         checks++;
         if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
            failures++;
            $display("FAIL basic cyc=%0d got an=%h seg=%h ft=%b want an=%h seg=%h ft=%b",
                     cycle, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
         end
         if (frame_tick === 1'b1) begin
            checks++;
            if (last_tick >= 0 && cycle - last_tick != FRAME || last_tick < 0 && cycle != 34) begin
               failures++;
               $display("FAIL tick_period got tick at %0d (prev %0d) want spacing %0d",
                        cycle, last_tick, FRAME);
            end
            last_tick = cycle;
         end
      end
   endtask

   task automatic test_blanking();
      logic [16:0] pats [5];
      pats = '{{4'd0, 4'd0, 4'd5, 4'd0, 1'b1}, {4'd0, 4'd0, 4'd5, 4'd0, 1'b0},
               {4'd0, 4'd0, 4'd0, 4'd0, 1'b1}, {4'd0, 4'd12, 4'd0, 4'd3, 1'b1},
               {4'd15, 4'd0, 4'd0, 4'd0, 1'b1}};
      foreach (pats[k]) begin
         apply(pats[k][16:13], pats[k][12:9], pats[k][8:5], pats[k][4:1], pats[k][0]);
         run_checked("blanking", 2 * FRAME);
      end
   endtask

   task automatic test_mid_frame();
      apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      run_checked("mid_pre", FRAME);
      for (int i = 0; i < FRAME && m_p != 0; i++) run_checked("mid_align", 1);
      run_checked("mid_slot0", 1 + SD + 3);
      value4 = 4'd7;
      run_checked("mid_frame", 2 * FRAME);
   endtask

   task automatic test_init_edge();
      apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      run_checked("edge_pre", FRAME);
      for (int i = 0; i < FRAME && m_p != 0; i++) run_checked("edge_align", 1);
      value4 = 4'd7;
      run_checked("init_edge", 2 * FRAME);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12 * FRAME; i++) begin
         if ($urandom_range(0, 9) == 0)
            apply(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         run_checked("random", 1);
      end
   endtask

   task automatic test_async_reset();
      apply(4'd8, 4'd8, 4'd8, 4'd8, 1'b0);
      run_checked("async_pre", FRAME + 6);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got an=%h seg=%h ft=%b want an=f seg=ff ft=0",
                  an, seg, frame_tick);
      end
      do_reset();
      run_checked("post_reset", 2 * FRAME);
   endtask

   initial begin
      m_p = 0; m_bl = 1'b0;
      for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
      test_reset();
      test_basic();
      test_blanking();
      test_mid_frame();
      test_init_edge();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
